// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div, one bit per cycle: result XLEN+1 cycles after accept, held until out_ready.
// No new request is taken while busy. MULDIV_EARLY_OUT_EN lets trivial ops skip the iterations.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   m_q;
  logic [XLEN-1:0]   out_q;
  logic              out_valid_q;

  logic              a_signed, b_signed, sa, sb, b_zero, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag, m_init;
  logic [2*XLEN-1:0] acc_init;

  // Work on magnitudes; neg_d records the sign the final result must carry.
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;
    b_zero   = (b == '0);
    if (op[2]) neg_d = op[1] ? sa : ((sa ^ sb) & ~b_zero);
    else       neg_d = sa ^ sb;
    acc_init = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    m_init   = op[2] ? b_mag : a_mag;
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic              ovf, early;
  logic [2*XLEN-1:0] early_acc;

  // Preload the accumulator with what the iterations would have produced.
  always_comb begin
    ovf   = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    early = op[2] ? (b_zero || ovf) : ((a == '0) || b_zero);
    if (op[2] && b_zero) early_acc = {a_mag, {XLEN{1'b1}}};
    else if (ovf)        early_acc = {{XLEN{1'b0}}, MIN_NEG};
    else                 early_acc = '0;
  end
`endif

  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, res;

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_nxt  = {sum, acc_q[XLEN-1:1]};
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = shifted - {1'b0, m_q};
    div_nxt  = diff[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod_fix = neg_q ? -acc_q : acc_q;
    q_fix    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_fix    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = q_fix;
      default:                res = r_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      m_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            neg_q   <= neg_d;
            cnt_q   <= CNT_W'(XLEN);
            m_q     <= m_init;
`ifdef MULDIV_EARLY_OUT_EN
            acc_q   <= early ? early_acc : acc_init;
            state_q <= early ? DONE : CALC;
`else
            acc_q   <= acc_init;
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          acc_q <= op_q[2] ? div_nxt : mul_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_q       <= res;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
